// File: rtl/fsm_stim_gen.sv
// fsm_stim_gen: drives a {q1,q2} symbol stream that walks a downstream
// four-state fsm to a requested target state. It keeps a shadow copy of the
// downstream state, picks the next symbol from that shadow, and reports when
// the target has been reached.

package fsm_stages_pkg;

  typedef enum logic [1:0] {
    START = 2'b00,
    ODD   = 2'b01,
    EVEN  = 2'b10,
    FIN   = 2'b11
  } c_state;

  // Downstream fsm transition for one consumed symbol {q1,q2}.
  function automatic c_state fsm_next(input c_state cur, input logic [1:0] sym);
    c_state nxt;
    nxt = cur;
    case (cur)
      START: nxt = (sym == 2'b01) ? ODD : START;
      ODD: begin
        case (sym)
          2'b10:   nxt = EVEN;
          2'b01:   nxt = ODD;
          default: nxt = START;   // q1 == q2
        endcase
      end
      EVEN, FIN: begin
        case (sym)
          2'b01:   nxt = ODD;
          2'b11:   nxt = FIN;
          default: nxt = START;   // 00 or 10
        endcase
      end
      default: nxt = START;
    endcase
    return nxt;
  endfunction

  // Symbol that moves the downstream fsm one step closer to the target.
  // Always produces a symbol that changes or confirms state, so a request
  // whose target equals the current shadow still consumes at least one.
  function automatic logic [1:0] seek_sym(input c_state cur, input c_state tgt);
    logic [1:0] sym;
    sym = 2'b00;
    case (tgt)
      START: sym = 2'b00;
      ODD:   sym = 2'b01;
      EVEN:  sym = (cur == ODD) ? 2'b10 : 2'b01;
      FIN: begin
        case (cur)
          EVEN, FIN: sym = 2'b11;
          ODD:       sym = 2'b10;
          default:   sym = 2'b01;
        endcase
      end
      default: sym = 2'b00;
    endcase
    return sym;
  endfunction

  // Symbol driven while idle. Start, odd and fin have a self-loop symbol;
  // even has none, so it is left to fall back to start.
  function automatic logic [1:0] hold_sym(input c_state cur);
    logic [1:0] sym;
    sym = 2'b00;
    case (cur)
      ODD:     sym = 2'b01;
      FIN:     sym = 2'b11;
      default: sym = 2'b00;   // start and even
    endcase
    return sym;
  endfunction

endpackage

module fsm_stim_gen
  import fsm_stages_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  input  logic       step_en,
  input  logic       clr,
  output logic       q1,
  output logic       q2,
  output logic       busy,
  output logic       done,
  output logic [1:0] shadow_state,
  output logic [1:0] last_len
);

  c_state     shadow_reg;
  c_state     target_reg;
  logic       busy_reg;
  logic       done_reg;
  logic [1:0] count_reg;
  logic [1:0] last_len_reg;

  logic [1:0] sym;
  c_state     shadow_next;
  logic [1:0] count_inc;
  logic       consume;
  logic       reached;
  logic       accept;

  // Symbol selection depends only on registered state, so q1/q2 never
  // glitch with request or step_en inputs.
  always_comb begin
    sym = busy_reg ? seek_sym(shadow_reg, target_reg) : hold_sym(shadow_reg);
  end

  assign shadow_next = fsm_next(shadow_reg, sym);
  assign count_inc   = (count_reg == 2'd3) ? 2'd3 : count_reg + 2'd1;
  assign consume     = busy_reg && step_en;
  assign reached     = consume && (shadow_next == target_reg);
  assign accept      = req_valid && !busy_reg && !clr;

  // Shadow tracks the downstream fsm on every sampled step; clr resyncs it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_reg <= START;
    end else if (clr) begin
      shadow_reg <= START;
    end else if (step_en) begin
      shadow_reg <= shadow_next;
    end
  end

  // Request lifecycle: accept when idle, count consumed symbols, retire on
  // the step that lands on the target. A retire and a new accept cannot
  // collide because accept requires idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg   <= 1'b0;
      target_reg <= START;
      count_reg  <= 2'd0;
    end else if (clr) begin
      busy_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else if (accept) begin
      busy_reg   <= 1'b1;
      target_reg <= c_state'(req_target);
      count_reg  <= 2'd0;
    end else if (reached) begin
      busy_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else if (consume) begin
      count_reg <= count_inc;
    end
  end

  // Completion reporting: one-cycle done pulse and the final symbol count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_reg     <= 1'b0;
      last_len_reg <= 2'd0;
    end else begin
      done_reg <= 1'b0;
      if (!clr && reached) begin
        done_reg     <= 1'b1;
        last_len_reg <= count_inc;
      end
    end
  end

  assign req_ready    = !busy_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign q1           = sym[1];
  assign q2           = sym[0];
  assign shadow_state = shadow_reg;
  assign last_len     = last_len_reg;

endmodule

// File: tb/tb_fsm_stim_gen.sv
// Bench for fsm_stim_gen: a reference model of the downstream fsm predicts
// the symbol stream, length and final state of each request into queues,
// which are drained as the DUT consumes symbols and signals done.
`timescale 1ns/1ps
module tb_fsm_stim_gen;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic       step_en;
  logic       clr;
  logic       q1;
  logic       q2;
  logic       busy;
  logic       done;
  logic [1:0] shadow_state;
  logic [1:0] last_len;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] m_state;
  logic [1:0] sym_q[$];
  logic [1:0] len_q[$];
  logic [1:0] sh_q[$];

  fsm_stim_gen dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
    .req_ready(req_ready), .step_en(step_en), .clr(clr), .q1(q1), .q2(q2),
    .busy(busy), .done(done), .shadow_state(shadow_state), .last_len(last_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Downstream fsm: states 0 start, 1 odd, 2 even, 3 fin.
  function automatic logic [1:0] m_tr(input logic [1:0] s, input logic [1:0] y);
    logic [1:0] r;
    r = 2'd0;
    if (s == 2'd0)      r = (y == 2'b01) ? 2'd1 : 2'd0;
    else if (s == 2'd1) r = (y == 2'b10) ? 2'd2 : (y == 2'b01) ? 2'd1 : 2'd0;
    else                r = (y == 2'b01) ? 2'd1 : (y == 2'b11) ? 2'd3 : 2'd0;
    return r;
  endfunction

  function automatic logic [1:0] m_seek(input logic [1:0] s, input logic [1:0] t);
    logic [1:0] y;
    y = 2'b00;
    if (t == 2'd1) y = 2'b01;
    else if (t == 2'd2) y = (s == 2'd1) ? 2'b10 : 2'b01;
    else if (t == 2'd3) y = (s >= 2'd2) ? 2'b11 : (s == 2'd1) ? 2'b10 : 2'b01;
    return y;
  endfunction

  function automatic logic [1:0] m_hold(input logic [1:0] s);
    logic [1:0] y;
    y = (s == 2'd1) ? 2'b01 : (s == 2'd3) ? 2'b11 : 2'b00;
    return y;
  endfunction

  // Push the expected symbol stream, length and final state for a request.
  function automatic void predict(input logic [1:0] tgt);
    logic [1:0] s;
    logic [1:0] y;
    int n;
    s = m_state;
    n = 0;
    do begin
      y = m_seek(s, tgt);
      sym_q.push_back(y);
      s = m_tr(s, y);
      n++;
    end while (s != tgt && n < 4);
    len_q.push_back((n > 3) ? 2'd3 : n[1:0]);
    sh_q.push_back(s);
    m_state = s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    sym_q.delete();
    len_q.delete();
    sh_q.delete();
    m_state = 2'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_shadow"}, shadow_state, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_last_len"}, last_len, 0);
    check({tag, "_sym"}, {q1, q2}, 0);
    check({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic idle(input int n, input logic se);
    step_en = se;
    for (int i = 0; i < n; i++) begin
      if (se) m_state = m_tr(m_state, m_hold(m_state));
      tick();
      check("idle_shadow", shadow_state, m_state);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_sym", {q1, q2}, m_hold(m_state));
    end
  endtask

  // Issue one request; optionally drop step_en for stall_len cycles before
  // symbol number stall_at is consumed.
  task automatic run_req(input logic [1:0] tgt, input int stall_at, input int stall_len);
    int k;
    int cyc;
    logic [1:0] es;
    logic [1:0] exp_len;
    logic [1:0] exp_sh;
    if (step_en) m_state = m_tr(m_state, m_hold(m_state));
    predict(tgt);
    check("ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_target = tgt;
    tick();
    req_valid = 1'b0;
    step_en   = 1'b1;
    check("busy_set", busy, 1);
    check("ready_low", req_ready, 0);
    k = 0;
    cyc = 0;
    while (busy && cyc < 16) begin
      es = (sym_q.size() > 0) ? sym_q[0] : 2'b00;
      if (k == stall_at) begin
        step_en = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          tick();
          cyc++;
          check("stall_sym", {q1, q2}, es);
          check("stall_busy", busy, 1);
          check("stall_done", done, 0);
          check("stall_shadow", shadow_state, (k == 1) ? 1 : shadow_state);
        end
        step_en = 1'b1;
      end
      check("sym", {q1, q2}, es);
      if (sym_q.size() > 0) sym_q.delete(0);
      k++;
      tick();
      cyc++;
    end
    check("timeout", busy, 0);
    exp_len = (len_q.size() > 0) ? len_q.pop_front() : 2'd0;
    exp_sh  = (sh_q.size() > 0) ? sh_q.pop_front() : 2'd0;
    check("done", done, 1);
    check("last_len", last_len, exp_len);
    check("shadow", shadow_state, exp_sh);
    check("ready_done", req_ready, 1);
    check("sym_left", sym_q.size(), 0);
    $display("req target=%0d symbols=%0d last_len=%0d shadow=%0d", tgt, k, last_len, shadow_state);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_target = 2'd0;
    step_en    = 1'b0;
    clr        = 1'b0;
    m_state    = 2'd0;
    #2 reset = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    reset = 1'b1;

    // Start -> fin: 01, 10, 11
    step_en = 1'b1;
    run_req(2'd3, -1, 0);

    // Fin held with step_en low, then odd in one symbol
    idle(2, 1'b0);
    run_req(2'd1, -1, 0);

    // Back-to-back in the done cycle: odd -> even
    run_req(2'd2, -1, 0);

    // Even -> even needs 01, 10; then idle stepping drops even to start
    idle(2, 1'b0);
    run_req(2'd2, -1, 0);
    idle(1, 1'b1);

    // Start -> fin with a 4-cycle stall after the first symbol
    run_req(2'd3, 1, 4);

    // Back to start, then clr after the second symbol of a fin request
    run_req(2'd0, -1, 0);
    step_en = 1'b1;
    m_state = m_tr(m_state, m_hold(m_state));
    predict(2'd3);
    req_valid  = 1'b1;
    req_target = 2'd3;
    tick();
    req_valid = 1'b0;
    check("clr_busy_set", busy, 1);
    for (int i = 0; i < 2; i++) begin
      check("clr_sym", {q1, q2}, sym_q[0]);
      sym_q.delete(0);
      tick();
    end
    check("clr_still_busy", busy, 1);
    clr        = 1'b1;
    req_valid  = 1'b1;
    req_target = 2'd1;
    tick();
    clr       = 1'b0;
    req_valid = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_shadow", shadow_state, 0);
    check("clr_done", done, 0);
    check("clr_last_len", last_len, 1);
    flush_model();
    tick();
    check("clr_no_accept", busy, 0);
    check("clr_done_after", done, 0);
    $display("clr mid-request shadow=%0d busy=%0d last_len=%0d", shadow_state, busy, last_len);

    // Asynchronous reset mid-request
    predict(2'd3);
    req_valid  = 1'b1;
    req_target = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    check("rst_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1 check_reset_values("async_rst");
    $display("reset mid-request shadow=%0d busy=%0d", shadow_state, busy);
    flush_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_no_done", done, 0);
    run_req(2'd1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
